vram_bus_ctrl: RTL and testbench

- Timed VRAM bus sequencer. Sits directly upstream of the VRAM pins and level shifters, the same pins the trivial VRAM bringup drives statically.
- Accepts single read/write requests over a valid/ready handshake. Drives the address, the read/write strobes and the data-direction control with programmable setup, strobe and hold phases.
- Captures read data from both chips (A and B) and returns it with a one-cycle response pulse.
- Used by the VRAM pattern tester and, later, by PPU-side VRAM access logic.

---
 rtl/vram_bus_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_vram_bus_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_bus_ctrl.sv
// Timed VRAM bus sequencer: SETUP -> STROBE -> HOLD phases around one read/write.
// Optional rsp_parity output enabled by defining VRAM_BUS_CTRL_PARITY_EN.
module vram_bus_ctrl #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [14:0] req_addr,
  input  logic        req_we_a,
  input  logic        req_we_b,
  input  logic [7:0]  req_wdata_a,
  input  logic [7:0]  req_wdata_b,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata_a,
  output logic [7:0]  rsp_rdata_b,
`ifdef VRAM_BUS_CTRL_PARITY_EN
  output logic        rsp_parity,
`endif
  output logic        lvl_va_dir,
  output logic        lvl_vd_dir,
  output logic        vrd_n,
  output logic        vawr_n,
  output logic        vbwr_n,
  output logic        va14,
  output logic [13:0] vaa,
  output logic [13:0] vab,
  output logic [7:0]  vda_o,
  output logic [7:0]  vdb_o,
  input  logic [7:0]  vda_i,
  input  logic [7:0]  vdb_i
);

  localparam int unsigned MAX_C = (SETUP_CYCLES > STROBE_CYCLES) ?
                                  ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                                  ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int unsigned CW = (MAX_C < 2) ? 1 : $clog2(MAX_C + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  cnt_t        r_cnt;
  cnt_t        w_cnt_nxt;
  logic        w_accept;
  logic        w_enter_strobe;
  logic        w_leave_strobe;
  logic        w_leave_hold;

  logic        r_write;
  logic        r_we_a;
  logic        r_we_b;
  logic        r_vrd_n;
  logic        r_vawr_n;
  logic        r_vbwr_n;
  logic        r_va14;
  logic [13:0] r_addr;
  logic [7:0]  r_vda_o;
  logic [7:0]  r_vdb_o;
  logic        r_vd_dir;
  logic        r_rsp_valid;
  logic [7:0]  r_rdata_a;
  logic [7:0]  r_rdata_b;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_accept       = 1'b0;
    w_enter_strobe = 1'b0;
    w_leave_strobe = 1'b0;
    w_leave_hold   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = cnt_t'(SETUP_CYCLES - 1);
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_enter_strobe = 1'b1;
          w_state_nxt    = S_STROBE;
          w_cnt_nxt      = cnt_t'(STROBE_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - cnt_t'(1);
        end
      end
      S_STROBE: begin
        if (r_cnt == '0) begin
          w_leave_strobe = 1'b1;
          w_state_nxt    = S_HOLD;
          w_cnt_nxt      = cnt_t'(HOLD_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - cnt_t'(1);
        end
      end
      default: begin
        if (r_cnt == '0) begin
          w_leave_hold = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - cnt_t'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Strobe registers change one edge ahead of the phase they belong to,
  // so the pins are low exactly while the FSM sits in STROBE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_write     <= 1'b0;
      r_we_a      <= 1'b0;
      r_we_b      <= 1'b0;
      r_vrd_n     <= 1'b1;
      r_vawr_n    <= 1'b1;
      r_vbwr_n    <= 1'b1;
      r_va14      <= 1'b0;
      r_addr      <= '0;
      r_vda_o     <= '0;
      r_vdb_o     <= '0;
      r_vd_dir    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata_a   <= '0;
      r_rdata_b   <= '0;
    end else begin
      r_rsp_valid <= w_leave_hold;
      if (w_accept) begin
        r_write  <= req_write;
        r_we_a   <= req_we_a;
        r_we_b   <= req_we_b;
        r_va14   <= req_addr[14];
        r_addr   <= req_addr[13:0];
        r_vda_o  <= req_wdata_a;
        r_vdb_o  <= req_wdata_b;
        r_vd_dir <= req_write;
      end else if (r_state == S_IDLE) begin
        r_vd_dir <= 1'b0;
      end
      if (w_enter_strobe) begin
        if (r_write) begin
          r_vawr_n <= ~r_we_a;
          r_vbwr_n <= ~r_we_b;
        end else begin
          r_vrd_n <= 1'b0;
        end
      end
      if (w_leave_strobe) begin
        r_vrd_n  <= 1'b1;
        r_vawr_n <= 1'b1;
        r_vbwr_n <= 1'b1;
        if (!r_write) begin
          r_rdata_a <= vda_i;
          r_rdata_b <= vdb_i;
        end
      end
    end
  end

`ifdef VRAM_BUS_CTRL_PARITY_EN
  logic r_parity;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_leave_strobe && !r_write) begin
      r_parity <= ^{vda_i, vdb_i};
    end
  end
  assign rsp_parity = r_parity;
`endif

  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata_a = r_rdata_a;
  assign rsp_rdata_b = r_rdata_b;
  assign lvl_va_dir  = 1'b1;
  assign lvl_vd_dir  = r_vd_dir;
  assign vrd_n       = r_vrd_n;
  assign vawr_n      = r_vawr_n;
  assign vbwr_n      = r_vbwr_n;
  assign va14        = r_va14;
  assign vaa         = r_addr;
  assign vab         = r_addr;
  assign vda_o       = r_vda_o;
  assign vdb_o       = r_vdb_o;

endmodule

// File: tb/tb_vram_bus_ctrl.sv
// Bench for vram_bus_ctrl: vector table, hand-written corner sequences and
// randomized transactions checked against a phase-window reference model.
module tb_vram_bus_ctrl;

  localparam int unsigned S = 2;
  localparam int unsigned T = 3;
  localparam int unsigned H = 1;
  localparam int unsigned L = 1 + S + T + H;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [14:0] req_addr = '0;
  logic        req_we_a = 1'b0;
  logic        req_we_b = 1'b0;
  logic [7:0]  req_wdata_a = '0;
  logic [7:0]  req_wdata_b = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata_a;
  logic [7:0]  rsp_rdata_b;
  logic        lvl_va_dir;
  logic        lvl_vd_dir;
  logic        vrd_n;
  logic        vawr_n;
  logic        vbwr_n;
  logic        va14;
  logic [13:0] vaa;
  logic [13:0] vab;
  logic [7:0]  vda_o;
  logic [7:0]  vdb_o;
  logic [7:0]  vda_i = '0;
  logic [7:0]  vdb_i = '0;
`ifdef VRAM_BUS_CTRL_PARITY_EN
  logic        rsp_parity;
`endif

  vram_bus_ctrl #(
    .SETUP_CYCLES (S),
    .STROBE_CYCLES(T),
    .HOLD_CYCLES  (H)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_we_a   (req_we_a),
    .req_we_b   (req_we_b),
    .req_wdata_a(req_wdata_a),
    .req_wdata_b(req_wdata_b),
    .rsp_valid  (rsp_valid),
    .rsp_rdata_a(rsp_rdata_a),
    .rsp_rdata_b(rsp_rdata_b),
`ifdef VRAM_BUS_CTRL_PARITY_EN
    .rsp_parity (rsp_parity),
`endif
    .lvl_va_dir (lvl_va_dir),
    .lvl_vd_dir (lvl_vd_dir),
    .vrd_n      (vrd_n),
    .vawr_n     (vawr_n),
    .vbwr_n     (vbwr_n),
    .va14       (va14),
    .vaa        (vaa),
    .vab        (vab),
    .vda_o      (vda_o),
    .vdb_o      (vdb_o),
    .vda_i      (vda_i),
    .vdb_i      (vdb_i)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Reference model state: what the bus should show between transactions.
  logic [14:0] m_addr = '0;
  logic [7:0]  m_wda  = '0;
  logic [7:0]  m_wdb  = '0;
  logic [7:0]  m_rda  = '0;
  logic [7:0]  m_rdb  = '0;
  logic        m_par  = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clock) begin
    if (!reset) chk("strobe_excl", 32'(!vrd_n && (!vawr_n || !vbwr_n)), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clock);
      chk("idle_ready", req_ready, 1);
      chk("idle_rsp", rsp_valid, 0);
      chk("idle_strobes", {vrd_n, vawr_n, vbwr_n}, 3'b111);
      chk("idle_dir", lvl_vd_dir, 0);
      chk("idle_addr", {va14, vaa}, m_addr);
      chk("idle_vab", vab, m_addr[13:0]);
      chk("idle_wdata", {vda_o, vdb_o}, {m_wda, m_wdb});
      chk("idle_rdata", {rsp_rdata_a, rsp_rdata_b}, {m_rda, m_rdb});
    end
  endtask

  // Called just after a negedge; ends at the negedge of the response cycle.
  task automatic run_txn(input logic wr, input logic [14:0] addr, input logic wea, input logic web,
                         input logic [7:0] wda, input logic [7:0] wdb,
                         input logic [7:0] ina, input logic [7:0] inb);
    logic in_strobe;
    chk("ready_at_req", req_ready, 1);
    vda_i       = ina;
    vdb_i       = inb;
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_we_a    = wea;
    req_we_b    = web;
    req_wdata_a = wda;
    req_wdata_b = wdb;
    @(posedge clock);
    m_addr = addr;
    m_wda  = wda;
    m_wdb  = wdb;
    for (int unsigned k = 1; k <= L; k++) begin
      #1;
      if (k < L) begin
        req_valid   = 1'b1;
        req_write   = 1'($urandom);
        req_addr    = 15'($urandom);
        req_we_a    = 1'($urandom);
        req_we_b    = 1'($urandom);
        req_wdata_a = 8'($urandom);
        req_wdata_b = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clock);
      in_strobe = (k >= S + 1) && (k <= S + T);
      chk("addr", {va14, vaa}, addr);
      chk("vab", vab, addr[13:0]);
      chk("wdata", {vda_o, vdb_o}, {wda, wdb});
      chk("vd_dir", lvl_vd_dir, wr);
      chk("vrd_n", vrd_n, !(!wr && in_strobe));
      chk("vawr_n", vawr_n, !(wr && wea && in_strobe));
      chk("vbwr_n", vbwr_n, !(wr && web && in_strobe));
      chk("rsp_valid", rsp_valid, k == L);
      chk("ready_busy", req_ready, k == L);
      if (k == L && !wr) begin
        m_rda = ina;
        m_rdb = inb;
        m_par = ^{ina, inb};
      end
      if (k == 1 || k == L) chk("rdata", {rsp_rdata_a, rsp_rdata_b}, {m_rda, m_rdb});
`ifdef VRAM_BUS_CTRL_PARITY_EN
      if (k == L) chk("parity", rsp_parity, m_par);
`endif
    end
  endtask

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic        wea;
    logic        web;
    logic [7:0]  wda;
    logic [7:0]  wdb;
    logic [7:0]  ina;
    logic [7:0]  inb;
    logic        exp_va14;
    logic [13:0] exp_vaa;
    logic [7:0]  exp_rda;
    logic [7:0]  exp_rdb;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 15'h4ABC, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 8'hC3, 1'b1, 14'h0ABC, 8'h5A, 8'hC3};
    vecs[1] = '{1'b1, 15'h0123, 1'b1, 1'b0, 8'h11, 8'h22, 8'h99, 8'h99, 1'b0, 14'h0123, 8'h5A, 8'hC3};
    vecs[2] = '{1'b1, 15'h7FFF, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h12, 8'h34, 1'b1, 14'h3FFF, 8'h5A, 8'hC3};
    vecs[3] = '{1'b1, 15'h0000, 1'b1, 1'b1, 8'hAA, 8'h55, 8'h00, 8'h00, 1'b0, 14'h0000, 8'h5A, 8'hC3};
    vecs[4] = '{1'b0, 15'h3FFF, 1'b1, 1'b1, 8'h0F, 8'hF0, 8'h00, 8'hFF, 1'b0, 14'h3FFF, 8'h00, 8'hFF};
    vecs[5] = '{1'b0, 15'h4000, 1'b0, 1'b1, 8'h66, 8'h77, 8'h81, 8'h7E, 1'b1, 14'h0000, 8'h81, 8'h7E};

    @(negedge clock);
    chk("rst_ready", req_ready, 1);
    chk("rst_strobes", {vrd_n, vawr_n, vbwr_n}, 3'b111);
    chk("rst_addr", {va14, vaa, vab}, 29'd0);
    chk("rst_dir", {lvl_va_dir, lvl_vd_dir}, 2'b10);
    chk("rst_wdata", {vda_o, vdb_o}, 16'd0);
    chk("rst_rsp", {rsp_valid, rsp_rdata_a, rsp_rdata_b}, 17'd0);
`ifdef VRAM_BUS_CTRL_PARITY_EN
    chk("rst_parity", rsp_parity, 0);
`endif
    #2 reset = 1'b0;
    idle(10);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wea, vecs[i].web,
              vecs[i].wda, vecs[i].wdb, vecs[i].ina, vecs[i].inb);
      chk("vec_va14", va14, vecs[i].exp_va14);
      chk("vec_vaa", vaa, vecs[i].exp_vaa);
      chk("vec_rda", rsp_rdata_a, vecs[i].exp_rda);
      chk("vec_rdb", rsp_rdata_b, vecs[i].exp_rdb);
      idle(1);
    end

    // Write then read accepted in the write's response cycle.
    run_txn(1'b1, 15'h1234, 1'b1, 1'b1, 8'hDE, 8'hAD, 8'h00, 8'h00);
    chk("b2b_dir_before", lvl_vd_dir, 1);
    run_txn(1'b0, 15'h5678, 1'b0, 1'b0, 8'h00, 8'h00, 8'h3C, 8'hA5);
    idle(2);

    // Reset in the middle of a write strobe.
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_addr    = 15'h2222;
    req_we_a    = 1'b1;
    req_we_b    = 1'b1;
    req_wdata_a = 8'h44;
    req_wdata_b = 8'h88;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid_vawr_low", vawr_n, 0);
    #1 reset = 1'b1;
    #1;
    chk("mid_vawr_async", vawr_n, 1);
    chk("mid_vbwr_async", vbwr_n, 1);
    chk("mid_dir_async", lvl_vd_dir, 0);
    chk("mid_ready_async", req_ready, 1);
    repeat (2) @(negedge clock);
    chk("mid_rsp", rsp_valid, 0);
    reset  = 1'b0;
    m_addr = '0;
    m_wda  = '0;
    m_wdb  = '0;
    m_rda  = '0;
    m_rdb  = '0;
    m_par  = 1'b0;
    idle(10);
    run_txn(1'b0, 15'h4ABC, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 8'hC3);
    idle(1);

`ifdef VRAM_BUS_CTRL_PARITY_EN
    run_txn(1'b0, 15'h0001, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 8'h00);
    chk("parity_one", rsp_parity, 1);
    run_txn(1'b0, 15'h0002, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 8'h01);
    chk("parity_zero", rsp_parity, 0);
    idle(1);
`endif

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 15'($urandom), 1'($urandom), 1'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
